// File: rtl/sampletest_pipe.sv
// sampletest_pipe: pipelined sample-in-primitive edge test with backpressure, cull modes and saturating statistics.
// Edge products are registered in stage 1; hits are resolved in stage 2 and misses are dropped as bubbles.
module sampletest_pipe #(
    parameter int SIGFIG     = 24,
    parameter int RADIX      = 10,
    parameter int VERTS      = 3,
    parameter int AXIS       = 3,
    parameter int COLORS     = 3,
    parameter int PIPE_DEPTH = 2,
    parameter int CNT_W      = 32
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_R16S,
    input  logic        [COLORS-1:0][SIGFIG-1:0]           color_R16U,
    input  logic signed [1:0][SIGFIG-1:0]                  sample_R16S,
    input  logic        [1:0]                              cull_mode_R16H,
    input  logic                                           validSamp_R16H,
    output logic                                           ready_R16H,
    output logic signed [AXIS-1:0][SIGFIG-1:0]             hit_R18S,
    output logic        [COLORS-1:0][SIGFIG-1:0]           color_R18U,
    output logic                                           hit_valid_R18H,
    input  logic                                           hit_ready_R18H,
    input  logic                                           clr_cnt_R16H,
    output logic        [CNT_W-1:0]                        samp_cnt_U,
    output logic        [CNT_W-1:0]                        hit_cnt_U
);
    localparam int PW = 2 * SIGFIG + 2;
    localparam int DW = PW + 1;
    localparam int NS = PIPE_DEPTH - 1;

    if (!(VERTS == 3 || VERTS == 4) || PIPE_DEPTH < 2 || AXIS < 3 || RADIX < 0 || RADIX > SIGFIG) begin : g_bad_params
        $error("sampletest_pipe: illegal parameter set");
    end

    logic adv, accept, unused;
    assign adv        = hit_ready_R18H | ~hit_valid_R18H;
    assign ready_R16H = adv;
    assign accept     = validSamp_R16H & adv;
    assign unused     = ^tri_R16S;

    logic signed [SIGFIG:0] xs [VERTS];
    logic signed [SIGFIG:0] ys [VERTS];
    logic [AXIS-1:0][SIGFIG-1:0] hit_in;
    always_comb begin
        hit_in    = '0;
        hit_in[0] = sample_R16S[0];
        hit_in[1] = sample_R16S[1];
        hit_in[2] = tri_R16S[0][2];
        for (int v = 0; v < VERTS; v++) begin
            xs[v] = (SIGFIG+1)'($signed(tri_R16S[v][0])) - (SIGFIG+1)'($signed(sample_R16S[0]));
            ys[v] = (SIGFIG+1)'($signed(tri_R16S[v][1])) - (SIGFIG+1)'($signed(sample_R16S[1]));
        end
    end

    logic                          s1_v;
    logic [1:0]                    s1_mode;
    logic [AXIS-1:0][SIGFIG-1:0]   s1_hit;
    logic [COLORS-1:0][SIGFIG-1:0] s1_col;
    logic signed [PW-1:0]          pa [VERTS];
    logic signed [PW-1:0]          pb [VERTS];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v    <= 1'b0;
            s1_mode <= '0;
            s1_hit  <= '0;
            s1_col  <= '0;
            for (int v = 0; v < VERTS; v++) begin
                pa[v] <= '0;
                pb[v] <= '0;
            end
        end else if (adv) begin
            s1_v    <= validSamp_R16H;
            s1_mode <= cull_mode_R16H;
            s1_hit  <= hit_in;
            s1_col  <= color_R16U;
            for (int v = 0; v < VERTS; v++) begin
                pa[v] <= PW'(xs[v]) * PW'(ys[(v + 1) % VERTS]);
                pb[v] <= PW'(xs[(v + 1) % VERTS]) * PW'(ys[v]);
            end
        end
    end

    // odd edges are strict so a sample on a shared edge lands in exactly one primitive
    logic neg, pos, hit;
    logic signed [DW-1:0] d;
    always_comb begin
        neg = 1'b1;
        pos = 1'b1;
        d   = '0;
        for (int v = 0; v < VERTS; v++) begin
            d   = DW'(pa[v]) - DW'(pb[v]);
            neg = neg & ((v % 2 == 1) ? d[DW-1] : (d[DW-1] | ~|d));
            pos = pos & ((v % 2 == 1) ? (~d[DW-1] & |d) : ~d[DW-1]);
        end
        hit = (s1_mode == 2'b10) ? pos : (s1_mode == 2'b00) ? (pos | neg) : neg;
    end

    logic [NS-1:0]                 pv;
    logic [AXIS-1:0][SIGFIG-1:0]   ph [NS];
    logic [COLORS-1:0][SIGFIG-1:0] pc [NS];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv <= '0;
            for (int k = 0; k < NS; k++) begin
                ph[k] <= '0;
                pc[k] <= '0;
            end
        end else if (adv) begin
            pv[0] <= s1_v & hit;
            ph[0] <= s1_hit;
            pc[0] <= s1_col;
            for (int k = 1; k < NS; k++) begin
                pv[k] <= pv[k-1];
                ph[k] <= ph[k-1];
                pc[k] <= pc[k-1];
            end
        end
    end
    assign hit_valid_R18H = pv[NS-1];
    assign hit_R18S       = ph[NS-1];
    assign color_R18U     = pc[NS-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_cnt_U <= '0;
            hit_cnt_U  <= '0;
        end else begin
            samp_cnt_U <= clr_cnt_R16H ? '0 : (accept && ~&samp_cnt_U) ? samp_cnt_U + CNT_W'(1) : samp_cnt_U;
            hit_cnt_U  <= clr_cnt_R16H ? '0 : (hit_valid_R18H && hit_ready_R18H && ~&hit_cnt_U) ? hit_cnt_U + CNT_W'(1) : hit_cnt_U;
        end
    end
endmodule

// File: tb/tb_sampletest_pipe.sv
// tb_sampletest_pipe: directed vectors with a scoreboard queue checked by an independent output monitor.
module tb_sampletest_pipe;
    localparam int SF = 24;
    localparam int V  = 3;
    localparam int AX = 3;
    localparam int C  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [V-1:0][AX-1:0][SF-1:0] tri_in;
    logic [C-1:0][SF-1:0]         col_in;
    logic [1:0][SF-1:0]           samp_in;
    logic [1:0]                   mode_in;
    logic                         valid_in, hit_ready, clr;
    logic                         ready, hv;
    logic [AX-1:0][SF-1:0]        hit_o;
    logic [C-1:0][SF-1:0]         col_o;
    logic [31:0]                  samp_cnt, hit_cnt;
    logic                         ready2, hv2;
    logic [AX-1:0][SF-1:0]        hit2;
    logic [C-1:0][SF-1:0]         col2;
    logic [1:0]                   samp2, hcnt2;

    sampletest_pipe #(.SIGFIG(SF), .RADIX(10), .VERTS(V), .AXIS(AX), .COLORS(C), .PIPE_DEPTH(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .tri_R16S(tri_in), .color_R16U(col_in), .sample_R16S(samp_in),
        .cull_mode_R16H(mode_in), .validSamp_R16H(valid_in), .ready_R16H(ready), .hit_R18S(hit_o),
        .color_R18U(col_o), .hit_valid_R18H(hv), .hit_ready_R18H(hit_ready), .clr_cnt_R16H(clr),
        .samp_cnt_U(samp_cnt), .hit_cnt_U(hit_cnt));

    sampletest_pipe #(.SIGFIG(SF), .RADIX(10), .VERTS(V), .AXIS(AX), .COLORS(C), .PIPE_DEPTH(2), .CNT_W(2)) sat (
        .clk(clk), .rst(rst), .tri_R16S(tri_in), .color_R16U(col_in), .sample_R16S(samp_in),
        .cull_mode_R16H(mode_in), .validSamp_R16H(valid_in), .ready_R16H(ready2), .hit_R18S(hit2),
        .color_R18U(col2), .hit_valid_R18H(hv2), .hit_ready_R18H(hit_ready), .clr_cnt_R16H(clr),
        .samp_cnt_U(samp2), .hit_cnt_U(hcnt2));

    typedef struct packed {
        logic [AX-1:0][SF-1:0] h;
        logic [C-1:0][SF-1:0]  c;
    } exp_t;
    exp_t q[$];
    exp_t me;
    int tests = 0, fails = 0, exp_samp = 0, exp_hit = 0;
    logic [AX-1:0][SF-1:0] snap_h;
    logic [C-1:0][SF-1:0]  snap_c;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [SF-1:0] sc(input int n);
        return SF'(n * 1024);
    endfunction

    // triangle (0,0),(0,8),(8,0); swap exchanges vertices 1 and 2
    task automatic send(input int sx, input int sy, input bit swap, input logic [1:0] mode, input bit is_hit, input int seed);
        exp_t e;
        bit acc = 1'b0;
        tri_in       = '0;
        tri_in[0][0] = sc(0);
        tri_in[0][1] = sc(0);
        tri_in[0][2] = sc(seed + 3);
        tri_in[1][0] = sc(swap ? 8 : 0);
        tri_in[1][1] = sc(swap ? 0 : 8);
        tri_in[1][2] = sc(seed + 4);
        tri_in[2][0] = sc(swap ? 0 : 8);
        tri_in[2][1] = sc(swap ? 8 : 0);
        tri_in[2][2] = sc(seed + 5);
        samp_in[0]   = sc(sx);
        samp_in[1]   = sc(sy);
        mode_in      = mode;
        for (int k = 0; k < C; k++) col_in[k] = SF'(seed * 16 + k + 1);
        e.h      = {sc(seed + 3), sc(sy), sc(sx)};
        e.c      = col_in;
        valid_in = 1'b1;
        for (int n = 0; n < 60 && !acc; n++) begin
            @(negedge clk);
            if (ready) begin
                acc = 1'b1;
                exp_samp++;
                if (is_hit) begin
                    q.push_back(e);
                    exp_hit++;
                end
            end
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        check("accept", acc, 1);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("drain_empty", q.size(), 0);
        check("samp_cnt", samp_cnt, exp_samp);
        check("hit_cnt", hit_cnt, exp_hit);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && hv === 1'b1 && hit_ready === 1'b1) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_hit: got %0h expected no beat", hit_o);
            end else begin
                me = q.pop_front();
                check("hit_xyz", hit_o, me.h);
                check("hit_color", col_o, me.c);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tri_in = '0; col_in = '0; samp_in = '0; mode_in = 2'b01;
        valid_in = 1'b0; hit_ready = 1'b1; clr = 1'b0;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", hv, 0);
        check("rst_ready", ready, 1);
        check("rst_hit", hit_o, 0);
        check("rst_color", col_o, 0);
        check("rst_samp", samp_cnt, 0);
        check("rst_hcnt", hit_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        send(2, 2, 0, 2'b01, 1, 1);
        @(negedge clk);
        check("lat_t1", hv, 0);
        @(negedge clk);
        check("lat_t2", hv, 1);
        @(negedge clk);
        check("lat_samp", samp_cnt, 1);
        check("lat_hcnt", hit_cnt, 1);
        @(posedge clk);
        #1;

        send(2, 2, 1, 2'b01, 0, 2);
        send(2, 2, 1, 2'b00, 1, 3);
        send(2, 2, 1, 2'b10, 1, 4);
        send(2, 2, 1, 2'b11, 0, 5);
        send(2, 2, 0, 2'b11, 1, 6);
        send(4, 4, 0, 2'b01, 0, 7);
        send(0, 4, 0, 2'b01, 1, 8);
        send(4, 4, 0, 2'b00, 0, 9);
        drain();

        hit_ready = 1'b0;
        fork
            begin
                send(2, 2, 0, 2'b01, 1, 10);
                send(1, 1, 0, 2'b01, 1, 11);
                send(3, 1, 0, 2'b01, 1, 12);
                send(1, 3, 0, 2'b01, 1, 13);
            end
            begin
                for (int n = 0; n < 20 && !hv; n++) @(negedge clk);
                check("stall_fill", hv, 1);
                snap_h = hit_o;
                snap_c = col_o;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_ready", ready, 0);
                    check("stall_valid", hv, 1);
                    check("stall_hit", hit_o, snap_h);
                    check("stall_color", col_o, snap_c);
                end
                @(posedge clk);
                #1 hit_ready = 1'b1;
            end
        join
        drain();

        check("sat_samp", samp2, 3);
        check("sat_hit", hcnt2, 3);
        send(1, 1, 0, 2'b01, 1, 14);
        drain();
        check("sat_samp_hold", samp2, 3);
        check("sat_hit_hold", hcnt2, 3);

        clr = 1'b1;
        send(2, 2, 0, 2'b00, 1, 15);
        clr = 1'b0;
        check("clr_samp", samp_cnt, 0);
        check("clr_hcnt", hit_cnt, 0);
        check("clr_samp_sat", samp2, 0);
        exp_samp = 0;
        exp_hit  = 1;
        drain();

        hit_ready = 1'b0;
        send(2, 2, 0, 2'b01, 1, 16);
        send(1, 1, 0, 2'b01, 1, 17);
        #2 rst = 1'b0;
        #1;
        check("flush_valid", hv, 0);
        check("flush_ready", ready, 1);
        check("flush_hit", hit_o, 0);
        check("flush_color", col_o, 0);
        check("flush_samp", samp_cnt, 0);
        check("flush_hcnt", hit_cnt, 0);
        q.delete();
        exp_samp = 0;
        exp_hit  = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        hit_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("flush_quiet", hv, 0);
        end
        @(posedge clk);
        #1;
        send(3, 1, 0, 2'b01, 1, 18);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
